// File: rtl/gtp_rx_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gtp_rx_pkg
// Description : Shared constants and types for the GTP receive deframer.
//               K28_5        - comma/header K-character
//               rx_state_t   - deframer state machine states
//               lane_mode_t  - byte-lane alignment of the incoming stream
// Revision    : 1.0 - initial release
// ============================================================================
package gtp_rx_pkg;

    localparam logic [7:0] K28_5 = 8'hBC;

    typedef enum logic [1:0] {
        HUNT    = 2'd0,
        PAYLOAD = 2'd1,
        CHECK   = 2'd2,
        SKIP    = 2'd3
    } rx_state_t;

    typedef enum logic {
        ALIGNED = 1'b0,
        SHIFTED = 1'b1
    } lane_mode_t;

endpackage
`default_nettype wire

// File: rtl/gtp_rx_lane_align.sv
`default_nettype none
// ============================================================================
// Module      : gtp_rx_lane_align
// Description : Rebuilds logical 16-bit words from a possibly byte-shifted
//               GTP RX stream and detects a frame header on either lane.
// Ports       : clk, rst       - clock, synchronous active-high reset
//               i_rxdata       - raw RX data ([7:0] first on the wire)
//               i_rxcharisk    - raw K flags per byte
//               i_mode         - latched lane mode selecting the word mux
//               o_word         - logical word in the latched mode
//               o_word_isk     - logical K flags in the latched mode
//               o_hdr_det      - a header is present on either lane
//               o_hdr_mode     - lane on which the header was found
//               o_hdr_id       - channel ID carried by that header
// Revision    : 1.0 - initial release
// ============================================================================
module gtp_rx_lane_align
    import gtp_rx_pkg::*;
#(
    parameter logic [7:0] K_HEADER = K28_5,
    parameter int         ID_W     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [15:0]     i_rxdata,
    input  logic [1:0]      i_rxcharisk,
    input  lane_mode_t      i_mode,
    output logic [15:0]     o_word,
    output logic [1:0]      o_word_isk,
    output logic            o_hdr_det,
    output lane_mode_t      o_hdr_mode,
    output logic [ID_W-1:0] o_hdr_id
);

    logic [7:0]  r_prev_byte;
    logic        r_prev_k;
    logic [15:0] w_shift_word;
    logic [1:0]  w_shift_isk;
    logic        w_hdr_aligned;
    logic        w_hdr_shifted;

    // Upper byte of the previous cycle becomes the low byte of the next
    // logical word when the link delivers words offset by one byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev_byte <= 8'h00;
            r_prev_k    <= 1'b0;
        end else begin
            r_prev_byte <= i_rxdata[15:8];
            r_prev_k    <= i_rxcharisk[1];
        end
    end

    assign w_shift_word = {i_rxdata[7:0], r_prev_byte};
    assign w_shift_isk  = {i_rxcharisk[0], r_prev_k};

    // Exactly one K flag on the low logical byte; a double-K word never
    // qualifies as a header.
    assign w_hdr_aligned = (i_rxcharisk == 2'b01) && (i_rxdata[7:0] == K_HEADER);
    assign w_hdr_shifted = (w_shift_isk == 2'b01) && (r_prev_byte == K_HEADER);

    always_comb begin
        o_word     = i_rxdata;
        o_word_isk = i_rxcharisk;
        if (i_mode == SHIFTED) begin
            o_word     = w_shift_word;
            o_word_isk = w_shift_isk;
        end
    end

    // Aligned lane wins if both lanes ever claim a header in the same cycle.
    assign o_hdr_det  = w_hdr_aligned || w_hdr_shifted;
    assign o_hdr_mode = w_hdr_aligned ? ALIGNED : SHIFTED;
    assign o_hdr_id   = w_hdr_aligned ? i_rxdata[8 +: ID_W] : i_rxdata[0 +: ID_W];

endmodule
`default_nettype wire

// File: rtl/gtp_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module      : gtp_rx_deframer
// Description : Receive deframer for the inter-FPGA GTP link. Hunts for a
//               K28.5 header on either lane, filters by channel ID, forwards
//               payload words with sof/eof, checks the additive checksum and
//               keeps saturating error counters.
// Ports       : gt_rxusrclk_in, reset_in      - clock, sync active-high reset
//               gt_rxdata, gt_rxcharisk       - raw GTP RX user interface
//               ch_sel                        - accepted ID (all-ones = any)
//               wr_data/wr_en/wr_sof/wr_eof   - payload write port
//               frame_good, frame_bad         - per-frame status pulses
//               cksum_err_cnt, kchar_err_cnt,
//               drop_cnt                      - saturating error counters
// Revision    : 1.0 - initial release
// ============================================================================
module gtp_rx_deframer
    import gtp_rx_pkg::*;
#(
    parameter int         PAYLOAD_WORDS = 4,
    parameter logic [7:0] K_HEADER      = K28_5,
    parameter int         CH_ID_W       = 4,
    parameter int         ERR_CNT_W     = 16
) (
    input  logic                 gt_rxusrclk_in,
    input  logic                 reset_in,
    input  logic [15:0]          gt_rxdata,
    input  logic [1:0]           gt_rxcharisk,
    input  logic [CH_ID_W-1:0]   ch_sel,
    output logic [15:0]          wr_data,
    output logic                 wr_en,
    output logic                 wr_sof,
    output logic                 wr_eof,
    output logic                 frame_good,
    output logic                 frame_bad,
    output logic [ERR_CNT_W-1:0] cksum_err_cnt,
    output logic [ERR_CNT_W-1:0] kchar_err_cnt,
    output logic [ERR_CNT_W-1:0] drop_cnt
);

    localparam int                     c_cnt_w     = $clog2(PAYLOAD_WORDS + 1);
    localparam logic [c_cnt_w-1:0]     c_last_word = c_cnt_w'(PAYLOAD_WORDS - 1);
    localparam logic [c_cnt_w-1:0]     c_skip_last = c_cnt_w'(PAYLOAD_WORDS);
    localparam logic [CH_ID_W-1:0]     c_any_id    = '1;
    localparam logic [ERR_CNT_W-1:0]   c_cnt_max   = '1;

    rx_state_t            r_state, w_next_state;
    lane_mode_t           r_mode;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [15:0]          r_acc;

    logic [15:0]          w_word;
    logic [1:0]           w_word_isk;
    logic                 w_hdr_det;
    lane_mode_t           w_hdr_mode;
    logic [CH_ID_W-1:0]   w_hdr_id;

    logic                 w_kword;
    logic                 w_kabort;
    logic                 w_hunt_eval;
    logic                 w_accept;
    logic                 w_drop;
    logic                 w_write;
    logic                 w_check;

    logic [15:0]          r_wr_data;
    logic                 r_wr_en, r_wr_sof, r_wr_eof;
    logic                 r_frame_good, r_frame_bad;
    logic [ERR_CNT_W-1:0] r_cksum_err_cnt, r_kchar_err_cnt, r_drop_cnt;

    gtp_rx_lane_align #(
        .K_HEADER (K_HEADER),
        .ID_W     (CH_ID_W)
    ) u_lane_align (
        .clk         (gt_rxusrclk_in),
        .rst         (reset_in),
        .i_rxdata    (gt_rxdata),
        .i_rxcharisk (gt_rxcharisk),
        .i_mode      (r_mode),
        .o_word      (w_word),
        .o_word_isk  (w_word_isk),
        .o_hdr_det   (w_hdr_det),
        .o_hdr_mode  (w_hdr_mode),
        .o_hdr_id    (w_hdr_id)
    );

    assign w_kword = (w_word_isk != 2'b00);

    // Next-state logic. Any K-word that interrupts a frame is re-examined as a
    // header in the same cycle so a back-to-back frame is not lost.
    always_comb begin
        w_next_state = r_state;
        w_kabort     = 1'b0;
        w_hunt_eval  = 1'b0;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        w_write      = 1'b0;
        w_check      = 1'b0;
        case (r_state)
            HUNT: w_hunt_eval = 1'b1;
            PAYLOAD: begin
                if (w_kword) begin
                    w_kabort    = 1'b1;
                    w_hunt_eval = 1'b1;
                end else begin
                    w_write = 1'b1;
                    if (r_cnt == c_last_word) w_next_state = CHECK;
                end
            end
            CHECK: begin
                if (w_kword) begin
                    w_kabort    = 1'b1;
                    w_hunt_eval = 1'b1;
                end else begin
                    w_check      = 1'b1;
                    w_next_state = HUNT;
                end
            end
            SKIP: begin
                if (w_kword) begin
                    w_hunt_eval = 1'b1;
                end else if (r_cnt == c_skip_last) begin
                    w_next_state = HUNT;
                end
            end
            default: w_next_state = HUNT;
        endcase

        if (w_hunt_eval) begin
            w_next_state = HUNT;
            if (w_hdr_det) begin
                if ((ch_sel == c_any_id) || (w_hdr_id == ch_sel)) begin
                    w_accept     = 1'b1;
                    w_next_state = PAYLOAD;
                end else begin
                    w_drop       = 1'b1;
                    w_next_state = SKIP;
                end
            end
        end
    end

    always_ff @(posedge gt_rxusrclk_in) begin
        if (reset_in) begin
            r_state         <= HUNT;
            r_mode          <= ALIGNED;
            r_cnt           <= '0;
            r_acc           <= 16'h0000;
            r_wr_data       <= 16'h0000;
            r_wr_en         <= 1'b0;
            r_wr_sof        <= 1'b0;
            r_wr_eof        <= 1'b0;
            r_frame_good    <= 1'b0;
            r_frame_bad     <= 1'b0;
            r_cksum_err_cnt <= '0;
            r_kchar_err_cnt <= '0;
            r_drop_cnt      <= '0;
        end else begin
            r_state <= w_next_state;

            if (w_hunt_eval && w_hdr_det) r_mode <= w_hdr_mode;

            if (w_accept || w_drop) begin
                r_cnt <= '0;
            end else if ((r_state == PAYLOAD) || (r_state == SKIP)) begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end

            if (w_accept) begin
                r_acc <= 16'h0000;
            end else if (w_write) begin
                r_acc <= r_acc + w_word;
            end

            r_wr_data    <= w_word;
            r_wr_en      <= w_write;
            r_wr_sof     <= w_write && (r_cnt == '0);
            r_wr_eof     <= w_write && (r_cnt == c_last_word);
            r_frame_good <= w_check && (w_word == r_acc);
            r_frame_bad  <= (w_check && (w_word != r_acc)) || w_kabort;

            if (w_check && (w_word != r_acc) && (r_cksum_err_cnt != c_cnt_max))
                r_cksum_err_cnt <= r_cksum_err_cnt + ERR_CNT_W'(1);
            if (w_kabort && (r_kchar_err_cnt != c_cnt_max))
                r_kchar_err_cnt <= r_kchar_err_cnt + ERR_CNT_W'(1);
            if (w_drop && (r_drop_cnt != c_cnt_max))
                r_drop_cnt <= r_drop_cnt + ERR_CNT_W'(1);
        end
    end

    assign wr_data       = r_wr_data;
    assign wr_en         = r_wr_en;
    assign wr_sof        = r_wr_sof;
    assign wr_eof        = r_wr_eof;
    assign frame_good    = r_frame_good;
    assign frame_bad     = r_frame_bad;
    assign cksum_err_cnt = r_cksum_err_cnt;
    assign kchar_err_cnt = r_kchar_err_cnt;
    assign drop_cnt      = r_drop_cnt;

endmodule
`default_nettype wire

// File: doc/gtp_rx_deframer.md
# gtp_rx_deframer

Parametrised receive deframer for the inter-FPGA GTP link, sitting between the GTP transceiver's RX user interface and the receive FIFO. It hunts for a K28.5 header on either byte lane and realigns byte-shifted streams. It filters frames by channel ID, forwards PAYLOAD_WORDS 16-bit payload words with start/end markers, and verifies a trailing 16-bit additive checksum. It reports per-frame good/bad status and saturating error counters.

## Interface
- PAYLOAD_WORDS, 4: payload words per frame; minimum 1.
- K_HEADER, 8'hBC: header K-character (K28.5).
- CH_ID_W, 4: channel ID width.
- ERR_CNT_W, 16: error counter width.
- gt_rxusrclk_in  in  1  sole clock; all logic on its rising edge.
- reset_in  in  1  synchronous, active-high reset.
- gt_rxdata  in  16  RX data; wire order is [7:0] then [15:8].
- gt_rxcharisk  in  2  K flags; bit0 marks [7:0], bit1 marks [15:8].
- ch_sel  in  CH_ID_W  accepted channel ID; all-ones accepts any ID.
- wr_data  out  16  realigned payload word.
- wr_en  out  1  wr_data valid.
- wr_sof  out  1  with wr_en, first payload word.
- wr_eof  out  1  with wr_en, last payload word.
- frame_good  out  1  one-cycle pulse, checksum matched.
- frame_bad  out  1  one-cycle pulse, checksum mismatch or abort.
- cksum_err_cnt, kchar_err_cnt, drop_cnt  out  ERR_CNT_W each  saturating counters.

## Operation
- Lane alignment:
  - A header with charisk=2'b01 selects ALIGNED mode: logical word = gt_rxdata.
  - A header with charisk=2'b10 selects SHIFTED mode: logical word = {gt_rxdata[7:0], previous gt_rxdata[15:8]}.
  - The logical charisk is realigned the same way.
  - Mode is latched at the header and held until the state machine returns to HUNT.
- Frame: header word {ID byte, K_HEADER}, then PAYLOAD_WORDS payload words, then a checksum word equal to the sum of the payload words mod 2^16.
- State HUNT:
  - Logical word = {id, K_HEADER} with logical charisk=2'b01 is a header.
  - id[CH_ID_W-1:0]==ch_sel, or ch_sel all-ones: go to PAYLOAD and clear the word counter and checksum accumulator.
  - Any other id: go to SKIP and increment drop_cnt.
  - All other words are ignored; charisk=2'b11 is not a header.
- State PAYLOAD: each word drives wr_en=1 and is added to the accumulator. wr_sof is set on word 0 and wr_eof on word PAYLOAD_WORDS-1. After the last word, go to CHECK.
- State CHECK: compare the word with the accumulator. Pulse frame_good on a match. On a mismatch, pulse frame_bad and increment cksum_err_cnt. Return to HUNT.
- State SKIP: consume PAYLOAD_WORDS+1 words without writing, then go to HUNT.
- Abort on a logical charisk≠0 in PAYLOAD or CHECK:
  - Stop writing (no wr_eof), pulse frame_bad, increment kchar_err_cnt.
  - The same word is evaluated as a HUNT header in that same cycle, so a back-to-back header is not lost.
  - In SKIP, a K-word also returns the machine to HUNT the same way, but without counter or pulse.
- Payload is written before it is verified. The consumer discards the frame on frame_bad.
- Counters saturate at all-ones and are never wrapped.

## Timing
- Reset: state HUNT, mode ALIGNED.
  - Zeroed: wr_data, wr_en, wr_sof, wr_eof, frame_good, frame_bad, all counters, accumulator, previous-byte register.
- Reset mid-frame: the frame is silently dropped, with no eof and no frame_bad.
- All outputs are registered.
- ALIGNED mode: wr_data appears 1 cycle after its word on gt_rxdata.
- SHIFTED mode: wr_data appears 1 cycle after the cycle carrying its upper byte.
- frame_good/frame_bad fire 1 cycle after the checksum word, i.e. 1 cycle after wr_eof with continuous data. Continuous data is required; there is no idle insertion inside a frame.
- Back-to-back frames are allowed: a header immediately after a checksum word is accepted, since CHECK returns to HUNT on the next cycle.
- Widths:
  - Word counter is $clog2(PAYLOAD_WORDS+1) bits.
  - Accumulator is 16 bits and wraps on carry.

## Structure
- Package gtp_rx_pkg holds:
  - K28_5 = 8'hBC.
  - State enum {HUNT, PAYLOAD, CHECK, SKIP}.
  - Lane enum {ALIGNED, SHIFTED}.
- Sub-module gtp_rx_lane_align:
  - Contains the previous-byte register and the mode mux.
  - Outputs the logical word, logical charisk and a header-detect flag.
- The top holds the FSM, accumulator, counters and output registers.

## Test plan
- Aligned frame, ch_sel=4'h3: header {8'h03,8'hBC}/01, payload 1111,2222,3333,4444, checksum AAAA -> four writes with sof on 1111 and eof on 4444, then frame_good.
- Same frame shifted by one byte (header with charisk=10) -> identical wr_data sequence, one cycle later, then frame_good.
- Checksum word AAAB -> four writes, then frame_bad and cksum_err_cnt=1.
- ID 8'h05 with ch_sel=4'h3 -> no writes, drop_cnt=1. The next frame with ID 03 is accepted. With ch_sel=4'hF, ID 05 is accepted.
- Header inside the payload after 2 words -> 2 writes without eof, frame_bad, kchar_err_cnt=1. The new frame is then received intact.
- reset_in asserted after payload word 2 -> all outputs 0 on the next cycle with no pulses. Counters saturate: preload near all-ones, send bad frames, and cksum_err_cnt holds at FFFF.
